flags_collector: RTL
====================

// Module: flags_collector
// PURPOSE
//   Producer side of the matmul overflow-flags register. Gathers per-PE over/underflow
//   events during a matmul run into a sticky MAX_DIM*MAX_DIM bit vector. At run end it
//   issues one write (write_enable_o + data_o) that the flags register captures.
//   Sits between the matmul PE array/controller and the flags register, same clock domain.
// PARAMETERS
//   DATA_WIDTH  32                       operand data width (bus-format compatibility only)
//   BUS_WIDTH   64                       bus width; width of data_o
//   MAX_DIM     BUS_WIDTH/DATA_WIDTH     max matrix dimension; flag vector is MAX_DIM^2 bits
//   IDX_W       (MAX_DIM>1)?$clog2(MAX_DIM):1   row/col index width (derived; not overridden)
// PORTS
//   clk_i          in   1          clock, rising edge
//   rst_ni         in   1          asynchronous active-low reset
//   start_i        in   1          pulse: new matmul run begins; clears collected flags
//   pe_valid_i     in   1          PE event strobe; row/col/ovf valid this cycle
//   pe_row_i       in   IDX_W      row of reporting PE
//   pe_col_i       in   IDX_W      column of reporting PE
//   pe_ovf_i       in   1          1 = PE over/underflowed this result
//   done_i         in   1          pulse: matmul run complete
//   rd_active_i    in   1          bus read of flags register in progress; defers commit
//   write_enable_o out  1          one-cycle write strobe to flags register
//   data_o         out  BUS_WIDTH  {zeros, flags[MAX_DIM^2-1:0]}; flag bit = row*MAX_DIM+col
//   busy_o         out  1          high in COLLECT or COMMIT
//   ovf_any_o      out  1          OR of collected flags (live)
// BEHAVIOUR
//   Reset (async, rst_ni=0): state=IDLE, flags=0, write_enable_o=0, data_o=0, busy_o=0, ovf_any_o=0.
//   States: IDLE, COLLECT, COMMIT.
//   IDLE: start_i -> clear flags, go COLLECT next edge. done_i/pe_valid_i ignored.
//   COLLECT: on pe_valid_i & pe_ovf_i & row<MAX_DIM & col<MAX_DIM set flags[row*MAX_DIM+col]
//     (sticky; pe_ovf_i=0 never clears a bit). Out-of-range indices ignored.
//     done_i -> COMMIT; event in same cycle as done_i is still captured.
//     start_i (no done_i) -> restart: flags cleared, stay COLLECT; start_i with event same
//     cycle: clear wins, event dropped. start_i & done_i together: done_i wins.
//   COMMIT: if rd_active_i=0: write_enable_o=1 for exactly that cycle, data_o=flags -> IDLE.
//     if rd_active_i=1: hold, write_enable_o=0, retry each cycle (no timeout).
//     pe_valid_i, start_i, done_i ignored in COMMIT.
//   Latency: done_i at edge N, rd_active_i=0 -> write_enable_o high in cycle N+1 only.
//   data_o registered; upper BUS_WIDTH-MAX_DIM^2 bits always 0; holds last committed value
//     between commits (cleared only by reset). flags restart clears internal vector only.
//   write_enable_o never high two consecutive cycles; never high outside COMMIT exit cycle.
//   Reset mid-run: no write issued; flags lost.
// STRUCTURE
//   Shared include flags_defs.vh: state encodings (IDLE=2'd0, COLLECT=2'd1, COMMIT=2'd2),
//     flag-index width/position macros; shared with the flags register and matmul control.
//   One sub-module: flags_index_decoder (row,col,en -> one-hot MAX_DIM^2 set mask, range check).
//   Top: FSM + sticky flag register + output register.
// TESTING (MAX_DIM=2, BUS_WIDTH=64)
//   1 reset mid-COLLECT with flags=4'b0101 -> all outputs 0, state IDLE, no strobe.
//   2 start; ovf at (0,1),(1,1); done; rd_active=0 -> one-cycle strobe, data_o=64'h...000A.
//   3 start; ovf (1,0); done while rd_active=1 for 3 cycles -> strobe on 4th cycle, data_o=64'h4.
//   4 start; ovf (0,0); start again; ovf (1,1); done -> data_o=64'h8 (restart cleared bit 0).
//   5 ovf (1,0) same cycle as done -> captured, data_o=64'h4; pe_ovf_i=0 events leave 0.
//   6 done_i in IDLE / events in COMMIT -> no strobe, data_o unchanged; idx 2 (MAX_DIM=3 build) range.

Source files
------------

// File: rtl/flags_collector_pkg.sv
// Shared definitions for the matmul overflow-flags path: FSM state encoding and flag-bit placement.
package flags_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    // Flag bit for PE (row, col) in a dim x dim array, row-major.
    function automatic int flag_pos(input int row, input int col, input int dim);
        return row * dim + col;
    endfunction

endpackage

// File: rtl/flags_index_decoder.sv
// Turns a PE (row, col) report into a one-hot set mask over the MAX_DIM^2 flag vector.
module flags_index_decoder
    import flags_collector_pkg::*;
#(
    parameter int MAX_DIM = 2,
    parameter int IDX_W   = 1
) (
    input  logic [IDX_W-1:0]           row,
    input  logic [IDX_W-1:0]           col,
    input  logic                       en,
    output logic [MAX_DIM*MAX_DIM-1:0] set_mask
);

    // Indices at or beyond MAX_DIM match no (r, c) pair and so produce an empty mask.
    always_comb begin
        set_mask = '0;
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                if (en && (row == IDX_W'(r)) && (col == IDX_W'(c))) begin
                    set_mask[flag_pos(r, c, MAX_DIM)] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/flags_collector.sv
// Collects sticky per-PE overflow flags during a matmul run and writes them once to the
// flags register when the run completes, deferring while a bus read of that register is active.
module flags_collector
    import flags_collector_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BUS_WIDTH  = 64,
    parameter  int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 pe_valid_i,
    input  logic [IDX_W-1:0]     pe_row_i,
    input  logic [IDX_W-1:0]     pe_col_i,
    input  logic                 pe_ovf_i,
    input  logic                 done_i,
    input  logic                 rd_active_i,
    output logic                 write_enable_o,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 busy_o,
    output logic                 ovf_any_o
);

    localparam int NFLAGS = MAX_DIM * MAX_DIM;

    state_e               state_q, state_d;
    logic [NFLAGS-1:0]    flags_q, flags_d;
    logic [NFLAGS-1:0]    set_mask;
    logic                 we_q, we_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;

    flags_index_decoder #(
        .MAX_DIM (MAX_DIM),
        .IDX_W   (IDX_W)
    ) u_decoder (
        .row      (pe_row_i),
        .col      (pe_col_i),
        .en       (pe_valid_i & pe_ovf_i),
        .set_mask (set_mask)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            flags_q <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            we_q    <= we_d;
            data_q  <= data_d;
        end
    end

    // done_i outranks a restart, and a restart outranks an event in the same cycle.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        we_d    = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    flags_d = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (done_i) begin
                    flags_d = flags_q | set_mask;
                    state_d = ST_COMMIT;
                end else if (start_i) begin
                    flags_d = '0;
                end else begin
                    flags_d = flags_q | set_mask;
                end
            end
            ST_COMMIT: begin
                if (!rd_active_i) begin
                    we_d    = 1'b1;
                    data_d  = BUS_WIDTH'(flags_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign write_enable_o = we_q;
    assign data_o         = data_q;
    assign busy_o         = (state_q == ST_COLLECT) || (state_q == ST_COMMIT);
    assign ovf_any_o      = |flags_q;

endmodule
